// File: rtl/mb_pattern_generator.sv
// Mainband training pattern generator: per-lane LFSR, valid-framing and lane-ID bursts for the serialiser.
// Optional per-lane-ID burst (cw=11) is built only when MB_PATGEN_PERLANE_ID_EN is defined.
module mb_pattern_generator #(
  parameter int          NUM_LANES = 16,
  parameter logic [22:0] SEED_BASE = 23'h1DBFBC
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_mainband_pattern_generator_cw,
  input  logic                   i_val_pattern_en,
  input  logic                   i_burst_count,
  output logic [NUM_LANES*8-1:0] o_lane_data,
  output logic [7:0]             o_valid_lane,
  output logic                   o_mb_active,
  output logic                   o_pattern_finished
);

  localparam logic [1:0] CW_CLEAR = 2'b01;
  localparam logic [1:0] CW_LFSR  = 2'b10;
`ifdef MB_PATGEN_PERLANE_ID_EN
  localparam logic [1:0] CW_LANEID = 2'b11;
`endif

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    VALID,
`ifdef MB_PATGEN_PERLANE_ID_EN
    LANEID,
`endif
    DONE
  } state_t;

  state_t                 state;
  logic [9:0]             beat_cnt;
  logic                   len_4k;
  logic                   fin_pend;
  logic [22:0]            lfsr_q   [NUM_LANES];
  logic [22:0]            lfsr_nxt [NUM_LANES];
  logic [NUM_LANES*8-1:0] lfsr_data;
  logic                   req_clear;
  logic                   req_data;
  logic                   req_lid;
  logic                   req_none;
  logic                   last_beat;

  function automatic logic [22:0] lane_seed(input int lane);
    return SEED_BASE ^ (23'(lane) << 16);
  endfunction

  assign req_clear = (i_mainband_pattern_generator_cw == CW_CLEAR);
  assign req_data  = (i_mainband_pattern_generator_cw == CW_LFSR);
`ifdef MB_PATGEN_PERLANE_ID_EN
  assign req_lid   = (i_mainband_pattern_generator_cw == CW_LANEID);
`else
  assign req_lid   = 1'b0;
`endif
  assign req_none  = !req_data && !req_lid && !i_val_pattern_en;
  assign last_beat = (beat_cnt == (len_4k ? 10'd511 : 10'd127));

  // One beat is eight Fibonacci shifts; bit k of the beat is the k-th shifted-out MSB.
  always_comb begin
    lfsr_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      logic [22:0] s;
      s = lfsr_q[i];
      for (int k = 0; k < 8; k++) begin
        lfsr_data[8*i+k] = s[22];
        s = {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
      end
      lfsr_nxt[i] = s;
    end
  end

`ifdef MB_PATGEN_PERLANE_ID_EN
  logic [NUM_LANES*8-1:0] lid_data;

  // Even beats carry the low byte of {1010, id, 1010}, odd beats the high byte.
  always_comb begin
    lid_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      logic [7:0] id;
      id = 8'(i);
      lid_data[8*i +: 8] = beat_cnt[0] ? {4'b1010, id[7:4]} : {id[3:0], 4'b1010};
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      beat_cnt           <= '0;
      len_4k             <= 1'b0;
      fin_pend           <= 1'b0;
      o_lane_data        <= '0;
      o_valid_lane       <= '0;
      o_mb_active        <= 1'b0;
      o_pattern_finished <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) lfsr_q[i] <= lane_seed(i);
    end else if (req_clear) begin
      state              <= IDLE;
      beat_cnt           <= '0;
      fin_pend           <= 1'b0;
      o_lane_data        <= '0;
      o_valid_lane       <= '0;
      o_mb_active        <= 1'b0;
      o_pattern_finished <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) lfsr_q[i] <= lane_seed(i);
    end else begin
      o_lane_data        <= '0;
      o_valid_lane       <= '0;
      o_mb_active        <= 1'b0;
      o_pattern_finished <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          len_4k   <= i_burst_count;
          if (req_data) state <= DATA;
`ifdef MB_PATGEN_PERLANE_ID_EN
          else if (req_lid) state <= LANEID;
`endif
          else if (i_val_pattern_en) state <= VALID;
        end
        DONE: begin
          // Finish pulse only on the first DONE cycle; stay here until the request drops.
          o_pattern_finished <= fin_pend;
          fin_pend           <= 1'b0;
          if (req_none) state <= IDLE;
        end
        default: begin
          if (req_none) begin
            state <= IDLE;
          end else begin
            o_mb_active <= 1'b1;
            beat_cnt    <= beat_cnt + 10'd1;
            if (last_beat) begin
              state    <= DONE;
              fin_pend <= 1'b1;
            end
            case (state)
              DATA: begin
                o_lane_data  <= lfsr_data;
                o_valid_lane <= 8'hFF;
                for (int i = 0; i < NUM_LANES; i++) lfsr_q[i] <= lfsr_nxt[i];
              end
              VALID: o_valid_lane <= 8'h0F;
`ifdef MB_PATGEN_PERLANE_ID_EN
              LANEID: begin
                o_lane_data  <= lid_data;
                o_valid_lane <= 8'hFF;
              end
`endif
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb_pattern_generator.sv
// Self-checking bench for mb_pattern_generator: scenario table, corner-case sequences and random
// stimulus, all compared cycle by cycle against a burst-level reference model.
module tb_mb_pattern_generator;

  localparam int          NUM_LANES = 16;
  localparam logic [22:0] SEED_BASE = 23'h1DBFBC;
`ifdef MB_PATGEN_PERLANE_ID_EN
  localparam bit LID_EN = 1'b1;
`else
  localparam bit LID_EN = 1'b0;
`endif

  logic                   i_clk = 1'b0;
  logic                   i_rst_n;
  logic [1:0]             cw;
  logic                   val_en;
  logic                   burst_count;
  logic [NUM_LANES*8-1:0] lane_data;
  logic [7:0]             valid_lane;
  logic                   mb_active;
  logic                   pattern_finished;

  int total = 0;
  int bad   = 0;

  mb_pattern_generator #(.NUM_LANES(NUM_LANES), .SEED_BASE(SEED_BASE)) dut (
    .i_clk                          (i_clk),
    .i_rst_n                        (i_rst_n),
    .i_mainband_pattern_generator_cw(cw),
    .i_val_pattern_en               (val_en),
    .i_burst_count                  (burst_count),
    .o_lane_data                    (lane_data),
    .o_valid_lane                   (valid_lane),
    .o_mb_active                    (mb_active),
    .o_pattern_finished             (pattern_finished)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a running burst is just a kind plus a count of beats still owed.
  logic [22:0]            m_lfsr [NUM_LANES];
  int                     m_kind;
  int                     m_left;
  int                     m_idx;
  bit                     m_hold;
  bit                     m_fin_due;
  logic [NUM_LANES*8-1:0] e_data;
  logic [7:0]             e_valid;
  logic                   e_active;
  logic                   e_fin;

  function automatic logic [30:0] lfsr_beat(input logic [22:0] seed);
    logic [22:0] s = seed;
    logic [7:0]  b = '0;
    for (int k = 0; k < 8; k++) begin
      b[k] = s[22];
      s = {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
    end
    return {b, s};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LANES; i++) m_lfsr[i] = SEED_BASE ^ (23'(i) << 16);
    m_kind = 0; m_left = 0; m_idx = 0; m_hold = 0; m_fin_due = 0;
    e_data = '0; e_valid = '0; e_active = 1'b0; e_fin = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic v, input logic bc);
    logic        want;
    logic [30:0] r;
    e_data = '0; e_valid = '0; e_active = 1'b0; e_fin = 1'b0;
    if (c == 2'b01) begin
      model_reset();
      return;
    end
    want = (c == 2'b10) || (LID_EN && c == 2'b11) || v;
    if (m_kind != 0) begin
      if (!want) begin
        m_kind = 0;
      end else begin
        e_active = 1'b1;
        case (m_kind)
          1: begin
            e_valid = 8'hFF;
            for (int i = 0; i < NUM_LANES; i++) begin
              r = lfsr_beat(m_lfsr[i]);
              e_data[8*i +: 8] = r[30:23];
              m_lfsr[i] = r[22:0];
            end
          end
          2: e_valid = 8'h0F;
          default: begin
            e_valid = 8'hFF;
            for (int i = 0; i < NUM_LANES; i++)
              e_data[8*i +: 8] = (m_idx % 2 == 0) ? 8'((i % 16) * 16 + 10) : 8'(160 + (i / 16) % 16);
          end
        endcase
        m_idx++;
        m_left--;
        if (m_left == 0) begin
          m_kind = 0; m_hold = 1; m_fin_due = 1;
        end
      end
    end else if (m_hold) begin
      e_fin = m_fin_due;
      m_fin_due = 0;
      if (!want) m_hold = 0;
    end else if (want) begin
      m_kind = (c == 2'b10) ? 1 : ((LID_EN && c == 2'b11) ? 3 : 2);
      m_left = bc ? 512 : 128;
      m_idx  = 0;
    end
  endtask

  task automatic checkOutput(input string name);
    total++;
    if (lane_data !== e_data || valid_lane !== e_valid || mb_active !== e_active || pattern_finished !== e_fin) begin
      bad++;
      $display("[TB] FAIL %s @%0t: got data=%h valid=%h active=%b fin=%b, want data=%h valid=%h active=%b fin=%b",
               name, $time, lane_data, valid_lane, mb_active, pattern_finished, e_data, e_valid, e_active, e_fin);
    end
  endtask

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s @%0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  // Drive at the falling edge, step the model on the rising edge, compare at the next falling edge.
  task automatic applyStimulus(input logic [1:0] c, input logic v, input logic bc);
    cw = c; val_en = v; burst_count = bc;
    @(posedge i_clk);
    if (!i_rst_n) model_reset();
    else model_step(c, v, bc);
    @(negedge i_clk);
    checkOutput("cycle");
  endtask

  typedef struct {
    logic [1:0] cw;
    logic       val;
    logic       bc;
    int         hold;
    int         exp_beats;
    logic [7:0] exp_valid;
    int         exp_fin;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          beats, vbad, fins;
    logic [7:0]  first1, first2, first3, seeded, exp2, l5_b0, l5_b1;
    logic [22:0] s;
    logic [30:0] r;

    vecs[0] = '{2'b10, 1'b0, 1'b0, 140, 128, 8'hFF, 1};
    vecs[1] = '{2'b00, 1'b1, 1'b0, 300, 128, 8'h0F, 1};
    vecs[2] = '{2'b10, 1'b1, 1'b0, 140, 128, 8'hFF, 1};
    vecs[3] = '{2'b10, 1'b0, 1'b1, 520, 512, 8'hFF, 1};
`ifdef MB_PATGEN_PERLANE_ID_EN
    vecs[4] = '{2'b11, 1'b0, 1'b0, 140, 128, 8'hFF, 1};
    vecs[5] = '{2'b11, 1'b1, 1'b0, 140, 128, 8'hFF, 1};
`else
    vecs[4] = '{2'b11, 1'b0, 1'b0, 140, 0, 8'h00, 0};
    vecs[5] = '{2'b11, 1'b1, 1'b0, 140, 128, 8'h0F, 1};
`endif
    vecs[6] = '{2'b00, 1'b1, 1'b1, 530, 512, 8'h0F, 1};

    r = lfsr_beat(SEED_BASE);
    seeded = r[30:23];
    s = SEED_BASE;
    for (int n = 0; n < 512; n++) begin
      r = lfsr_beat(s);
      s = r[22:0];
    end
    r = lfsr_beat(s);
    exp2 = r[30:23];

    i_rst_n = 1'b0;
    model_reset();
    for (int n = 0; n < 3; n++) applyStimulus(2'b00, 1'b0, 1'b0);
    i_rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      applyStimulus(2'b01, 1'b0, 1'b0);
      beats = 0; vbad = 0; fins = 0;
      for (int n = 0; n < vecs[v].hold + 3; n++) begin
        if (n < vecs[v].hold) applyStimulus(vecs[v].cw, vecs[v].val, vecs[v].bc);
        else applyStimulus(2'b00, 1'b0, 1'b0);
        if (mb_active) begin
          beats++;
          if (valid_lane !== vecs[v].exp_valid) vbad++;
        end
        if (pattern_finished) fins++;
      end
      check_val($sformatf("vec%0d_beats", v), beats, vecs[v].exp_beats);
      check_val($sformatf("vec%0d_valid_errs", v), vbad, 0);
      check_val($sformatf("vec%0d_finished", v), fins, vecs[v].exp_fin);
    end

    // Two 4K bursts without a clear continue the sequence; a clear restarts it.
    applyStimulus(2'b01, 1'b0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      beats = 0;
      for (int n = 0; n < 515; n++) begin
        applyStimulus(2'b10, 1'b0, 1'b1);
        if (mb_active) begin
          if (beats == 0 && b == 0) first1 = lane_data[7:0];
          if (beats == 0 && b == 1) first2 = lane_data[7:0];
          beats++;
        end
      end
      check_val($sformatf("burst4k_%0d_beats", b), beats, 512);
      for (int n = 0; n < 3; n++) applyStimulus(2'b00, 1'b0, 1'b0);
    end
    check_val("first_beat_seeded", first1, seeded);
    check_val("second_burst_continues", first2, exp2);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    check_val("no_beat_on_request_edge", mb_active, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    first3 = lane_data[7:0];
    check_val("rerun_after_clear", first3, seeded);
    for (int n = 0; n < 130; n++) applyStimulus(2'b00, 1'b0, 1'b0);

    // Abort at beat 50.
    applyStimulus(2'b01, 1'b0, 1'b0);
    beats = 0;
    for (int n = 0; n < 200 && beats < 50; n++) begin
      applyStimulus(2'b10, 1'b0, 1'b0);
      if (mb_active) beats++;
    end
    check_val("abort_reached_50", beats, 50);
    applyStimulus(2'b00, 1'b0, 1'b0);
    check_val("abort_outputs_zero", {lane_data[119:0], valid_lane, mb_active}, '0);
    fins = 0;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(2'b00, 1'b0, 1'b0);
      if (pattern_finished) fins++;
    end
    check_val("abort_no_finish", fins, 0);

    // Asynchronous reset at beat 300.
    applyStimulus(2'b01, 1'b0, 1'b0);
    beats = 0;
    for (int n = 0; n < 400 && beats < 300; n++) begin
      applyStimulus(2'b10, 1'b0, 1'b1);
      if (mb_active) beats++;
    end
    check_val("reset_reached_300", beats, 300);
    #2 i_rst_n = 1'b0;
    #1 check_val("reset_immediate_zero", {lane_data, valid_lane, mb_active, pattern_finished} != '0, 1'b0);
    model_reset();
    applyStimulus(2'b10, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    fins = 0;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(2'b00, 1'b0, 1'b0);
      if (pattern_finished) fins++;
    end
    check_val("reset_no_finish", fins, 0);

    // Lane-ID burst on lane 5 (or no activity when the feature is not built).
    applyStimulus(2'b01, 1'b0, 1'b0);
    beats = 0; l5_b0 = '0; l5_b1 = '0;
    for (int n = 0; n < 140; n++) begin
      applyStimulus(2'b11, 1'b0, 1'b0);
      if (mb_active) begin
        if (beats == 0) l5_b0 = lane_data[47:40];
        if (beats == 1) l5_b1 = lane_data[47:40];
        beats++;
      end
    end
`ifdef MB_PATGEN_PERLANE_ID_EN
    check_val("laneid_beats", beats, 128);
    check_val("lane5_beat0", l5_b0, 8'h5A);
    check_val("lane5_beat1", l5_b1, 8'hA0);
`else
    check_val("laneid_disabled_beats", beats, 0);
`endif
    for (int n = 0; n < 3; n++) applyStimulus(2'b00, 1'b0, 1'b0);

    // Random segments checked cycle by cycle against the model.
    for (int seg = 0; seg < 40; seg++) begin
      int          sel, len;
      logic [1:0]  c;
      logic        v, bc;
      sel = $urandom_range(0, 9);
      c   = (sel == 0) ? 2'b01 : (sel <= 4) ? 2'b10 : (sel <= 6) ? 2'b11 : 2'b00;
      v   = ($urandom_range(0, 2) == 0);
      bc  = ($urandom_range(0, 3) == 0);
      len = (c == 2'b01) ? 1 : $urandom_range(1, 200);
      for (int n = 0; n < len; n++) applyStimulus(c, v, bc);
    end
    for (int n = 0; n < 5; n++) applyStimulus(2'b00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mb_pattern_generator.md
# mb_pattern_generator

Mainband training pattern generator on the transmit side of the physical layer. It takes pattern-generator control from the link-training test sequencers and drives per-lane 8-bit-per-clock LFSR, valid-framing or per-lane-ID beats into the mainband serialiser. It signals burst completion back to the sequencer with a one-cycle `o_pattern_finished` pulse.

## Interface
Parameters:
- NUM_LANES, 16, number of data lanes.
- SEED_BASE, 23'h1DBFBC, LFSR seed base. `SEED_BASE[15:0]` must be non-zero.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_mainband_pattern_generator_cw  in  2  control word: 00 IDLE, 01 CLEAR_LFSR, 10 LFSR, 11 PER_LANE_ID.
- i_val_pattern_en  in  1  request a valid-lane training burst.
- i_burst_count  in  1  burst length: 0 = 1K UI (128 beats), 1 = 4K UI (512 beats).
- o_lane_data  out  NUM_LANES*8  lane i occupies bits [8i+7:8i]; bit 0 is the first UI serialised.
- o_valid_lane  out  8  valid-lane beat; bit 0 is the first UI.
- o_mb_active  out  1  high while a burst beat is on the outputs.
- o_pattern_finished  out  1  one-cycle pulse after the last beat of a burst.

## Operation
- One 23-bit Fibonacci LFSR per lane.
  - Seed for lane i: `SEED_BASE ^ (i << 16)`.
  - Per shift: `out = s[22]`; `fb = s[22]^s[20]^s[15]^s[7]^s[4]^s[1]`; `s <= {s[21:0], fb}`.
  - A beat is 8 successive shifts. Output bit k is the k-th shift's `out`.
- States: IDLE, DATA, VALID, LANEID, DONE.
- CLEAR_LFSR overrides everything, in any state:
  - all LFSRs reload their seeds;
  - the beat counter clears;
  - next state is IDLE and outputs are zero.
- Transitions from IDLE:
  - cw=10 → DATA.
  - cw=11 → LANEID.
  - i_val_pattern_en=1 with cw=00 → VALID.
  - cw=10 together with i_val_pattern_en=1 → DATA. The data burst has priority.
- Burst states (DATA, VALID, LANEID):
  - Each cycle emits one beat and increments the 10-bit beat counter.
  - When the counter reaches the burst length minus 1, the state moves to DONE.
  - If the request is withdrawn mid-burst (cw=00 and i_val_pattern_en=0), the state returns to IDLE with outputs zero. No finished pulse is issued and the LFSR state is retained.
- DONE:
  - Outputs are zero.
  - The block waits until cw≠10, cw≠11 and i_val_pattern_en=0, then goes to IDLE.
  - It does not re-arm while the request is still held.
- LFSRs advance only in DATA. They are not reseeded between bursts unless CLEAR_LFSR is issued.
- Beat contents per state:
  - DATA: LFSR beats on all lanes; o_valid_lane = 8'hFF.
  - VALID: o_valid_lane = 8'b00001111 (four UI high, then four low); o_lane_data = 0.
  - LANEID: 16-bit pattern {4'b1010, i[7:0], 4'b1010}, sent over two beats, low byte first, repeated; o_valid_lane = 8'hFF.
- i_burst_count is sampled on entry into a burst state and held for that burst.

## Timing
- All outputs are registered.
- Reset values: o_lane_data=0, o_valid_lane=0, o_mb_active=0, o_pattern_finished=0. State is IDLE, the counter is 0 and the LFSRs hold their seeds.
- If a request is sampled at edge N:
  - the first beat is on the outputs after edge N+1;
  - the last beat is after edge N+L, where L is 128 or 512;
  - o_pattern_finished is high for exactly the cycle after edge N+L+1, with o_mb_active=0.
- o_mb_active is high on exactly L consecutive cycles per completed burst.
- Reset asserted mid-burst: all outputs go to zero immediately and no finished pulse is issued.

## Configuration
- Macro: `MB_PATGEN_PERLANE_ID_EN`.
- When defined: cw=11 runs the per-lane-ID burst as described above.
- When undefined: cw=11 is a NOP.
  - The block behaves as for cw=00, except that i_val_pattern_en is still honoured.
  - The LANEID state and the lane-ID mux are not built.

## Test plan
- Reset, then cw=01 for 1 cycle, then cw=10 with i_burst_count=0 → 128 beats. Lane 0, first beat, matches a software model seeded 23'h1DBFBC. The finished pulse comes 1 cycle after the last beat.
- i_val_pattern_en=1 with i_burst_count=0 → 128 beats of o_valid_lane=8'h0F, o_lane_data=0, then one finished pulse. With the enable held, no second burst starts.
- cw=10 with i_burst_count=1, two back-to-back bursts separated by cw=00 and no clear → 512 beats each. The second burst continues the LFSR sequence. After cw=01 and a rerun, the first beat equals the seeded value.
- cw=10 and i_val_pattern_en=1 in the same cycle → DATA burst with o_valid_lane=8'hFF throughout.
- Abort at beat 50 (cw→00) → outputs zero the next cycle and no finished pulse. Reset asserted at beat 300 → all outputs are 0 immediately.
- With the macro defined, cw=11 → lane 5 alternates 8'h5A, 8'hA0 (bit 0 first), 128 beats total. With the macro undefined, cw=11 → no activity.
